// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: in-order instruction prefetch front end.
// Issues word-aligned fetch requests over a valid/ready handshake, accepts
// variable-latency in-order responses, and buffers instructions with their
// PCs in a DEPTH-entry FIFO that feeds decode. An EX redirect flushes the
// FIFO and drops every response still in flight.
//
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    in-order fetch responses
//   redirect, redirect_pc            taken branch/jump target from EX
//   instr_valid/ready                queue head handshake towards decode
//   instr_out, pc_out, pcplus4_out   queue head payload
module if_prefetch_queue #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pcplus4_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   count_nxt;

  // Handshake decode; a request slot is only offered when its response is
  // guaranteed a FIFO entry, so the queue can never overflow.
  always_comb begin
    credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;
    imem_req_valid  = reset & ~redirect & credit_ok;
    accept          = imem_req_valid & imem_req_ready;
    push            = imem_rsp_valid & (drop == '0) & ~redirect;
    pop             = instr_valid & instr_ready & ~redirect;
    outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    count_nxt       = count + CW'(push) - CW'(pop);
  end

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_out   = instr_mem[rd_ptr];
  assign pc_out      = pc_mem[rd_ptr];
  assign pcplus4_out = pc_mem[rd_ptr] + XLEN'(4);

  // Control state; redirect flushes the queue and marks every request still
  // in flight (after this cycle's accept/response) as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        drop     <= outstanding_nxt;
      end else begin
        count <= count_nxt;
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // FIFO payload storage; needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  // Environment/protocol guards.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count == FULL)));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed scoreboard bench for if_prefetch_queue.
// An imem model with programmable latency and ready pattern answers fetches;
// the main process pushes expected PC streams; a monitor pops and compares
// each instruction decode accepts.
module tb_if_prefetch_queue;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcplus4_out;

  if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out), .pcplus4_out(pcplus4_out)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // imem model ------------------------------------------------------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] cyc = '0;
  logic [31:0] lat = 32'd1;
  bit          rdy_mode = 1'b0;
  logic [15:0] rdy_pat = 16'b1011_0010_1110_0101;
  logic [31:0] exp_fetch = RESET_PC;
  int unsigned accepts = 0;
  bit          last_stall = 1'b0;
  logic [31:0] last_addr = '0;

  always @(posedge clk) begin
    cyc = cyc + 32'd1;
    #1;
    imem_req_ready = rdy_mode ? rdy_pat[cyc[3:0]] : 1'b1;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pend_q.delete();
      exp_fetch  = RESET_PC;
      last_stall = 1'b0;
    end else begin
      if (imem_rsp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
      if (redirect) begin
        check("req_blocked_on_redirect", 64'(imem_req_valid), 64'd0);
        exp_fetch  = redirect_pc;
        last_stall = 1'b0;
      end else begin
        if (last_stall && imem_req_valid)
          check("addr_stable_stall", 64'(imem_addr), 64'(last_addr));
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", 64'(imem_addr), 64'(exp_fetch));
          exp_fetch = exp_fetch + 32'd4;
          accepts++;
          pend_q.push_back('{addr: imem_addr, due: cyc + lat});
        end
        last_stall = imem_req_valid & ~imem_req_ready;
        last_addr  = imem_addr;
      end
    end
  end

  // Monitor ----------------------------------------------------------------
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("unexpected_instr", 64'(pc_out), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pc_out", 64'(pc_out), 64'(e));
        check("instr_out", 64'(instr_out), 64'(instr_of(e)));
        check("pcplus4_out", 64'(pcplus4_out), 64'(e + 32'd4));
      end
    end
  end

  // Stimulus ---------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic fill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Hold reset one cycle, then release it at the start of "cycle 0".
  task automatic restart();
    step();
    reset = 1'b0;
    step();
    fill(RESET_PC);
    step();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      step();
      @(negedge clk);
      n++;
    end
    check("wait_instr_valid", 64'(instr_valid), 64'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    step();
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
  endtask

  task automatic end_redirect(input logic [31:0] target);
    step();
    redirect = 1'b0;
    fill(target);
    @(negedge clk);
    check("flush_empty", 64'(instr_valid), 64'd0);
  endtask

  initial begin
    int base;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);

    // 1: first fetch timing and streaming, 1-cycle imem
    lat = 32'd1;
    instr_ready = 1'b1;
    restart();
    @(negedge clk);
    check("c0_req_valid", 64'(imem_req_valid), 64'd1);
    check("c0_req_addr", 64'(imem_addr), 64'(RESET_PC));
    check("c0_instr_valid", 64'(instr_valid), 64'd0);
    run(1);
    check("c1_instr_valid", 64'(instr_valid), 64'd0);
    run(1);
    check("c2_instr_valid", 64'(instr_valid), 64'd1);
    check("c2_pc_out", 64'(pc_out), 64'(RESET_PC));
    repeat (8) begin
      run(1);
      check("stream_valid", 64'(instr_valid), 64'd1);
    end

    // 2: decode stalled, credit limit of DEPTH
    instr_ready = 1'b0;
    restart();
    base = int'(accepts);
    @(negedge clk);
    run(10);
    check("stall_accepts", 64'(int'(accepts) - base), 64'(DEPTH));
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_head_pc", 64'(pc_out), 64'(RESET_PC));
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    run(10);

    // 3: latency 3, redirect with two requests in flight
    lat = 32'd3;
    restart();
    @(negedge clk);
    run(1);
    do_redirect(32'h100);
    end_redirect(32'h100);
    wait_valid(20);
    check("redir_first_pc", 64'(pc_out), 64'h100);
    run(8);

    // 4: redirect coinciding with a response and a pop
    lat = 32'd1;
    restart();
    @(negedge clk);
    run(5);
    do_redirect(32'h200);
    check("r4_rsp_valid", 64'(imem_rsp_valid), 64'd1);
    check("r4_instr_valid", 64'(instr_valid), 64'd1);
    end_redirect(32'h200);
    wait_valid(10);
    check("r4_first_pc", 64'(pc_out), 64'h200);
    run(6);

    // Back-to-back redirects, last wins
    lat = 32'd3;
    run(8);
    do_redirect(32'h300);
    do_redirect(32'h400);
    end_redirect(32'h400);
    wait_valid(30);
    check("b2b_first_pc", 64'(pc_out), 64'h400);
    run(6);

    // 5: imem_req_ready toggling
    lat = 32'd2;
    rdy_mode = 1'b1;
    run(40);
    rdy_mode = 1'b0;
    run(4);

    // 6: reset mid-stream with count=3, outstanding=1
    lat = 32'd4;
    instr_ready = 1'b0;
    restart();
    @(negedge clk);
    run(6);
    check("pre_rst_instr_valid", 64'(instr_valid), 64'd1);
    step();
    reset = 1'b0;
    #1;
    check("midrst_instr_valid", 64'(instr_valid), 64'd0);
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    lat = 32'd1;
    instr_ready = 1'b1;
    fill(RESET_PC);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("restart_addr", 64'(imem_addr), 64'(RESET_PC));
    wait_valid(10);
    check("restart_pc", 64'(pc_out), 64'(RESET_PC));
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
